// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready register pipeline of DEPTH stages with flush and occupancy.
// Optional stall/bubble performance counters are enabled by defining PIPE_REG_PERF_EN.
module pipe_reg_elastic #(
   parameter int                DATA_W    = 68,
   parameter int                DEPTH     = 1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                bubble_cnt
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  r_valid;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH:0]    w_ready;
   logic [DEPTH-1:0]  w_vin;
   logic [DATA_W-1:0] w_din [DEPTH];
   logic [OCC_W-1:0]  w_occ;

   // Ready ripples backwards from the output; w_ready[DEPTH] is the downstream sink.
   assign w_ready[DEPTH] = out_ready;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         assign w_ready[gi] = ~r_valid[gi] | w_ready[gi+1];
         if (gi == 0) begin : g_first
            assign w_vin[gi] = in_valid;
            assign w_din[gi] = in_data;
         end else begin : g_rest
            assign w_vin[gi] = r_valid[gi-1];
            assign w_din[gi] = r_data[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= RESET_VAL;
         end
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_ready[i]) begin
               r_valid[i] <= w_vin[i];
               // Bubbles leave the previous payload in place.
               if (w_vin[i]) r_data[i] <= w_din[i];
            end
         end
      end
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ = w_occ + OCC_W'(r_valid[i]);
      end
   end

   assign in_ready  = w_ready[0] & ~flush;
   assign out_valid = r_valid[DEPTH-1];
   assign out_data  = r_data[DEPTH-1];
   assign occupancy = w_occ;

`ifdef PIPE_REG_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_bubble_cnt;

   // Counters survive flush; only reset clears them. Both wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready) r_stall_cnt  <= r_stall_cnt + 32'd1;
         if (!out_valid && out_ready) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: DEPTH=1/2/3 instances share stimulus, each with its own scoreboard.
module tb_pipe_reg_elastic;

   localparam int W  = 68;
   localparam int I1 = 0;
   localparam int I2 = 1;
   localparam int I3 = 2;

`ifdef PIPE_REG_PERF_EN
   localparam logic [W-1:0] E_STALL = W'(5);
   localparam logic [W-1:0] E_BUB   = W'(3);
`else
   localparam logic [W-1:0] E_STALL = W'(0);
   localparam logic [W-1:0] E_BUB   = W'(0);
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;

   logic [2:0]   ir;
   logic [2:0]   ov;
   logic [W-1:0] od [3];
   logic [31:0]  sc [3];
   logic [31:0]  bc [3];
   logic [0:0]   occ1;
   logic [1:0]   occ2;
   logic [1:0]   occ3;

   always #5 clk = ~clk;

   pipe_reg_elastic #(.DATA_W(W), .DEPTH(1)) u_d1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[I1]), .in_data(in_data),
      .out_valid(ov[I1]), .out_ready(out_ready), .out_data(od[I1]),
      .occupancy(occ1), .stall_cnt(sc[I1]), .bubble_cnt(bc[I1]));

   pipe_reg_elastic #(.DATA_W(W), .DEPTH(2)) u_d2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[I2]), .in_data(in_data),
      .out_valid(ov[I2]), .out_ready(out_ready), .out_data(od[I2]),
      .occupancy(occ2), .stall_cnt(sc[I2]), .bubble_cnt(bc[I2]));

   pipe_reg_elastic #(.DATA_W(W), .DEPTH(3)) u_d3 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[I3]), .in_data(in_data),
      .out_valid(ov[I3]), .out_ready(out_ready), .out_data(od[I3]),
      .occupancy(occ3), .stall_cnt(sc[I3]), .bubble_cnt(bc[I3]));

   typedef struct {
      logic         iv;
      logic [W-1:0] din;
      logic         ordy;
      logic         e1_ov;
      logic [W-1:0] e1_od;
      logic [1:0]   e3_occ;
      logic         e3_ov;
      logic [W-1:0] e3_od;
      logic         e3_ir;
   } vec_t;

   vec_t         tv [7];
   logic [W-1:0] sbq [3][$];
   int           n_vec = 0;
   int           n_mis = 0;
   int           hs [3];
   logic         prev_stall [3];
   logic [W-1:0] prev_od [3];
   int           hs_start;

   function automatic vec_t mk(input logic iv, input int din, input logic ordy,
                               input logic e1_ov, input int e1_od, input int e3_occ,
                               input logic e3_ov, input int e3_od, input logic e3_ir);
      vec_t v;
      v.iv = iv; v.din = W'(din); v.ordy = ordy;
      v.e1_ov = e1_ov; v.e1_od = W'(e1_od);
      v.e3_occ = 2'(e3_occ); v.e3_ov = e3_ov; v.e3_od = W'(e3_od); v.e3_ir = e3_ir;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [W-1:0] din, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = din;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Scoreboard step: sample mid-cycle, i.e. the handshakes the next edge will perform.
   task automatic at_neg();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            sbq[i].delete();
            prev_stall[i] = 1'b0;
         end else begin
            if (prev_stall[i]) begin
               chk($sformatf("hold_valid[%0d]", i), W'(ov[i]), W'(1));
               chk($sformatf("hold_data[%0d]", i), od[i], prev_od[i]);
            end
            if (flush) begin
               chk($sformatf("flush_in_ready[%0d]", i), W'(ir[i]), W'(0));
               sbq[i].delete();
               prev_stall[i] = 1'b0;
            end else begin
               if (in_valid && ir[i]) sbq[i].push_back(in_data);
               if (ov[i] && out_ready) begin
                  hs[i]++;
                  if (sbq[i].size() == 0) begin
                     n_vec++;
                     n_mis++;
                     $display("FAIL sb_unexpected[%0d]: got %0h, expected no output", i, od[i]);
                  end else begin
                     chk($sformatf("sb_data[%0d]", i), od[i], sbq[i].pop_front());
                  end
               end
               prev_stall[i] = ov[i] && !out_ready;
               prev_od[i]    = od[i];
            end
         end
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic iv, input logic [W-1:0] din, input logic ordy, input logic fl);
      drive(iv, din, ordy, fl);
      at_neg();
      to_pos();
   endtask

   initial begin
      // Throughput/latency vectors: all pipelines start empty, out_ready held high.
      tv[0] = mk(1, 1, 1,  0, 0,  0, 0, 0, 1);
      tv[1] = mk(1, 2, 1,  1, 1,  1, 0, 0, 1);
      tv[2] = mk(1, 3, 1,  1, 2,  2, 0, 0, 1);
      tv[3] = mk(0, 0, 1,  1, 3,  3, 1, 1, 1);
      tv[4] = mk(0, 0, 1,  0, 3,  2, 1, 2, 1);
      tv[5] = mk(0, 0, 1,  0, 3,  1, 1, 3, 1);
      tv[6] = mk(0, 0, 1,  0, 3,  0, 0, 3, 1);

      for (int i = 0; i < 3; i++) begin
         hs[i] = 0;
         prev_stall[i] = 1'b0;
         prev_od[i] = '0;
      end
      reset = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_out_valid[%0d]", i), W'(ov[i]), W'(0));
         chk($sformatf("rst_out_data[%0d]", i), od[i], W'(0));
         chk($sformatf("rst_in_ready[%0d]", i), W'(ir[i]), W'(1));
         chk($sformatf("rst_stall[%0d]", i), W'(sc[i]), W'(0));
         chk($sformatf("rst_bubble[%0d]", i), W'(bc[i]), W'(0));
      end
      chk("rst_occ1", W'(occ1), W'(0));
      chk("rst_occ2", W'(occ2), W'(0));
      chk("rst_occ3", W'(occ3), W'(0));
      reset = 1'b0;

      // Table: 1-cycle latency on DEPTH=1, 3-cycle latency on DEPTH=3.
      for (int r = 0; r < 7; r++) begin
         drive(tv[r].iv, tv[r].din, tv[r].ordy, 1'b0);
         at_neg();
         chk($sformatf("tv%0d_d1_valid", r), W'(ov[I1]), W'(tv[r].e1_ov));
         chk($sformatf("tv%0d_d1_data", r), od[I1], tv[r].e1_od);
         chk($sformatf("tv%0d_d3_occ", r), W'(occ3), W'(tv[r].e3_occ));
         chk($sformatf("tv%0d_d3_valid", r), W'(ov[I3]), W'(tv[r].e3_ov));
         chk($sformatf("tv%0d_d3_data", r), od[I3], tv[r].e3_od);
         chk($sformatf("tv%0d_d3_in_ready", r), W'(ir[I3]), W'(tv[r].e3_ir));
         to_pos();
      end

      // Back-pressure on DEPTH=3: fill with A,B,C, D waits upstream.
      hs_start = hs[I3];
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, W'(32'hA + k), 1'b0, 1'b0);
         at_neg();
         chk($sformatf("bp%0d_occ3", k), W'(occ3), W'(k));
         chk($sformatf("bp%0d_in_ready3", k), W'(ir[I3]), W'(k < 3));
         to_pos();
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, W'(32'hD), 1'b0, 1'b0);
         at_neg();
         chk("bp_full_occ3", W'(occ3), W'(3));
         chk("bp_full_in_ready3", W'(ir[I3]), W'(0));
         chk("bp_full_data3", od[I3], W'(32'hA));
         to_pos();
      end
      drive(1'b1, W'(32'hD), 1'b1, 1'b0);
      at_neg();
      chk("bp_passthru_in_ready3", W'(ir[I3]), W'(1));
      to_pos();
      for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("bp_drained_count3", W'(hs[I3] - hs_start), W'(4));
      chk("bp_sb_empty3", W'(sbq[I3].size()), W'(0));

      // Flush with two valid stages and a simultaneous input offer.
      cycle(1'b1, W'(32'h51), 1'b1, 1'b0);
      cycle(1'b1, W'(32'h52), 1'b1, 1'b0);
      drive(1'b1, W'(32'h53), 1'b1, 1'b1);
      at_neg();
      chk("fl_pre_occ3", W'(occ3), W'(2));
      to_pos();
      drive(1'b0, '0, 1'b1, 1'b0);
      at_neg();
      chk("fl_occ3", W'(occ3), W'(0));
      chk("fl_valid3", W'(ov[I3]), W'(0));
      chk("fl_data3", od[I3], W'(0));
      chk("fl_valid1", W'(ov[I1]), W'(0));
      chk("fl_data1", od[I1], W'(0));
      to_pos();

      // Asynchronous reset between edges with two payloads in flight.
      cycle(1'b1, W'(32'h61), 1'b0, 1'b0);
      cycle(1'b1, W'(32'h62), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      at_neg();
      @(posedge clk);
      #1;
      chk("ar_pre_occ3", W'(occ3), W'(2));
      #2;
      reset = 1'b1;
      #1;
      chk("ar_occ3", W'(occ3), W'(0));
      chk("ar_valid3", W'(ov[I3]), W'(0));
      chk("ar_valid1", W'(ov[I1]), W'(0));
      chk("ar_data3", od[I3], W'(0));
      chk("ar_stall1", W'(sc[I1]), W'(0));
      chk("ar_bubble1", W'(bc[I1]), W'(0));
      at_neg();
      to_pos();
      reset = 1'b0;

      // Perf counters on DEPTH=1: 5 stalls, one handshake, 3 bubbles.
      cycle(1'b1, W'(32'h71), 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      at_neg();
      chk("perf_stall1", W'(sc[I1]), E_STALL);
      chk("perf_bubble1", W'(bc[I1]), E_BUB);
      to_pos();

      // DEPTH=2 with out_ready toggling: one item per two cycles in steady state.
      hs_start = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 8) hs_start = hs[I2];
         cycle(1'b1, W'(32'h100 + c), (c % 2) == 0, 1'b0);
      end
      chk("toggle_rate2", W'(hs[I2] - hs_start), W'(6));

      for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("final_sb_empty[%0d]", i), W'(sbq[i].size()), W'(0));
      end
      chk("final_occ3", W'(occ3), W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
